// File: rtl/axil_mem_responder_if.sv
// AXI4-Lite bus bundle for axil_mem_responder.
// The slave modport is the memory responder's view; the master modport is
// the view of whatever drives the link (bus master, adaptor or testbench).
interface axil_mem_responder_if;

  // read-address channel
  logic [31:0] s_araddr;
  logic        s_arvalid;
  logic        s_arready;
  logic [2:0]  s_arprot;

  // read-data channel
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rvalid;
  logic        s_rready;

  // write-address channel
  logic [31:0] s_awaddr;
  logic        s_awvalid;
  logic        s_awready;
  logic [2:0]  s_awprot;

  // write-data channel
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_wvalid;
  logic        s_wready;

  // write-response channel
  logic [1:0]  s_bresp;
  logic        s_bvalid;
  logic        s_bready;

  modport slave (
    input  s_araddr, s_arvalid, s_arprot,
    output s_arready,
    output s_rdata, s_rresp, s_rvalid,
    input  s_rready,
    input  s_awaddr, s_awvalid, s_awprot,
    output s_awready,
    input  s_wdata, s_wstrb, s_wvalid,
    output s_wready,
    output s_bresp, s_bvalid,
    input  s_bready
  );

  modport master (
    output s_araddr, s_arvalid, s_arprot,
    input  s_arready,
    input  s_rdata, s_rresp, s_rvalid,
    output s_rready,
    output s_awaddr, s_awvalid, s_awprot,
    input  s_awready,
    output s_wdata, s_wstrb, s_wvalid,
    input  s_wready,
    input  s_bresp, s_bvalid,
    output s_bready
  );

endinterface

// File: rtl/axil_mem_responder.sv
// axil_mem_responder: AXI4-Lite slave backed by a local word-addressed RAM.
// Read and write channels run as two independent FSMs sharing one
// simple-dual-port memory (one synchronous read port, one byte-enable write
// port). Memory contents are never touched by rst.
//
// Optional feature macro: AXIL_MEM_DECERR_EN
//   defined   -> out-of-window accesses answer DECERR (2'b11); reads return 0
//                and writes leave memory untouched.
//   undefined -> no range check; the word index wraps modulo the depth and
//                every response is OKAY.
module axil_mem_responder #(
  parameter logic [31:0] BASE       = 32'h0,
  parameter int          DEPTH_LOG2 = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  axil_mem_responder_if.slave  s_axil
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Read FSM: the RAM read is issued in R_READ, its registered output is
  // valid in R_LOAD and copied to the output register on leaving R_LOAD, so
  // rvalid rises two edges after the AR handshake.
  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_READ = 2'd1;
  localparam logic [1:0] R_LOAD = 2'd2;
  localparam logic [1:0] R_RESP = 2'd3;

  // Write FSM: W_IDLE collects AW and W in any order, W_WRITE performs the
  // single RAM write, W_RESP holds bvalid until the B handshake.
  localparam logic [1:0] W_IDLE  = 2'd0;
  localparam logic [1:0] W_WRITE = 2'd1;
  localparam logic [1:0] W_RESP  = 2'd2;

  // ---------------------------------------------------------------- storage
  logic [31:0]           r_mem [0:DEPTH-1];
  logic [31:0]           r_mem_rdata;

  // ------------------------------------------------------------ read state
  logic [1:0]            r_rstate;
  logic                  r_arready;
  logic                  r_rvalid;
  logic [31:0]           r_rdata;
  logic [1:0]            r_rresp;
  logic [DEPTH_LOG2-1:0] r_ar_idx;

  // ----------------------------------------------------------- write state
  logic [1:0]            r_wstate;
  logic                  r_awready;
  logic                  r_wready;
  logic                  r_bvalid;
  logic [1:0]            r_bresp;
  logic                  r_aw_got;
  logic                  r_w_got;
  logic [DEPTH_LOG2-1:0] r_aw_idx;
  logic [31:0]           r_wdata;
  logic [3:0]            r_wstrb;

  // ------------------------------------------------------- address decode
  // Offsets are plain 32-bit unsigned differences, so addresses below BASE
  // wrap to huge offsets and land out of range.
  logic [31:0]           w_ar_off;
  logic [31:0]           w_aw_off;
  logic [DEPTH_LOG2-1:0] w_ar_idx;
  logic [DEPTH_LOG2-1:0] w_aw_idx;

  assign w_ar_off = s_axil.s_araddr - BASE;
  assign w_aw_off = s_axil.s_awaddr - BASE;
  assign w_ar_idx = w_ar_off[DEPTH_LOG2+1:2];
  assign w_aw_idx = w_aw_off[DEPTH_LOG2+1:2];

`ifdef AXIL_MEM_DECERR_EN
  // In range iff every offset bit above the word-index field is zero.
  logic w_ar_in;
  logic w_aw_in;
  logic r_ar_in;
  logic r_aw_in;

  assign w_ar_in = (w_ar_off[31:DEPTH_LOG2+2] == '0);
  assign w_aw_in = (w_aw_off[31:DEPTH_LOG2+2] == '0);
`endif

  // Byte-offset bits and prot fields carry no meaning for a word memory.
  logic w_unused_ok;
  assign w_unused_ok = ^{w_ar_off, w_aw_off, s_axil.s_arprot, s_axil.s_awprot};

  // ------------------------------------------------------ handshake terms
  logic w_ar_hs;
  logic w_aw_hs;
  logic w_w_hs;
  logic w_aw_have;
  logic w_w_have;

  assign w_ar_hs   = s_axil.s_arvalid & r_arready;
  assign w_aw_hs   = s_axil.s_awvalid & r_awready;
  assign w_w_hs    = s_axil.s_wvalid  & r_wready;
  // "have" covers both the already-captured case and a capture this cycle.
  assign w_aw_have = r_aw_got | w_aw_hs;
  assign w_w_have  = r_w_got  | w_w_hs;

  // ------------------------------------------------------- write enables
  logic       w_mem_we;
  logic [3:0] w_byte_we;

`ifdef AXIL_MEM_DECERR_EN
  assign w_mem_we = (r_wstate == W_WRITE) & r_aw_in;
`else
  assign w_mem_we = (r_wstate == W_WRITE);
`endif

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign w_byte_we[gi] = w_mem_we & r_wstrb[gi];
    end
  endgenerate

  // RAM: byte-lane writes plus a registered read; a same-edge read of the
  // word being written returns the old contents.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (w_byte_we[i]) begin
        r_mem[r_aw_idx][8*i +: 8] <= r_wdata[8*i +: 8];
      end
    end
    if (r_rstate == R_READ) begin
      r_mem_rdata <= r_mem[r_ar_idx];
    end
  end

  // Read channel FSM: accept AR, wait out RAM latency, hold R until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b1;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= RESP_OKAY;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (w_ar_hs) begin
            r_ar_idx  <= w_ar_idx;
`ifdef AXIL_MEM_DECERR_EN
            r_ar_in   <= w_ar_in;
`endif
            r_arready <= 1'b0;
            r_rstate  <= R_READ;
          end
        end
        R_READ: begin
          r_rstate <= R_LOAD;
        end
        R_LOAD: begin
`ifdef AXIL_MEM_DECERR_EN
          if (r_ar_in) begin
            r_rdata <= r_mem_rdata;
            r_rresp <= RESP_OKAY;
          end else begin
            r_rdata <= '0;
            r_rresp <= RESP_DECERR;
          end
`else
          r_rdata <= r_mem_rdata;
          r_rresp <= RESP_OKAY;
`endif
          r_rvalid <= 1'b1;
          r_rstate <= R_RESP;
        end
        R_RESP: begin
          if (s_axil.s_rready) begin
            r_rvalid  <= 1'b0;
            r_arready <= 1'b1;
            r_rstate  <= R_IDLE;
          end
        end
        default: begin
          r_rstate <= R_IDLE;
        end
      endcase
    end
  end

  // Write channel FSM: capture AW and W independently, write once, answer B.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b1;
      r_wready  <= 1'b1;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_aw_got  <= 1'b0;
      r_w_got   <= 1'b0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (w_aw_hs) begin
            r_aw_idx  <= w_aw_idx;
`ifdef AXIL_MEM_DECERR_EN
            r_aw_in   <= w_aw_in;
`endif
            r_awready <= 1'b0;
            r_aw_got  <= 1'b1;
          end
          if (w_w_hs) begin
            r_wdata  <= s_axil.s_wdata;
            r_wstrb  <= s_axil.s_wstrb;
            r_wready <= 1'b0;
            r_w_got  <= 1'b1;
          end
          if (w_aw_have && w_w_have) begin
            r_wstate <= W_WRITE;
          end
        end
        W_WRITE: begin
`ifdef AXIL_MEM_DECERR_EN
          r_bresp <= r_aw_in ? RESP_OKAY : RESP_DECERR;
`else
          r_bresp <= RESP_OKAY;
`endif
          r_bvalid <= 1'b1;
          r_wstate <= W_RESP;
        end
        W_RESP: begin
          if (s_axil.s_bready) begin
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
            r_aw_got  <= 1'b0;
            r_w_got   <= 1'b0;
            r_wstate  <= W_IDLE;
          end
        end
        default: begin
          r_wstate <= W_IDLE;
        end
      endcase
    end
  end

  // ------------------------------------------------------------- outputs
  assign s_axil.s_arready = r_arready;
  assign s_axil.s_rvalid  = r_rvalid;
  assign s_axil.s_rdata   = r_rdata;
  assign s_axil.s_rresp   = r_rresp;
  assign s_axil.s_awready = r_awready;
  assign s_axil.s_wready  = r_wready;
  assign s_axil.s_bvalid  = r_bvalid;
  assign s_axil.s_bresp   = r_bresp;

endmodule
